// File: rtl/rcpu_defs_pkg.sv
// rcpu_defs_pkg: R-type opcode/funct codes, ALU-op encoding, field slicers and decoder.
package rcpu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[15:11];
    endfunction

    function automatic logic [4:0] f_shamt(input logic [31:0] w);
        return w[10:6];
    endfunction

    // Returns {legal, alu_op}; anything outside the supported R-type set is illegal.
    function automatic logic [4:0] decode(input logic [31:0] w);
        if (w[31:26] != OP_RTYPE) return 5'b0;
        case (w[5:0])
            F_ADD:   return {1'b1, ALU_ADD};
            F_ADDU:  return {1'b1, ALU_ADDU};
            F_SUB:   return {1'b1, ALU_SUB};
            F_SUBU:  return {1'b1, ALU_SUBU};
            F_AND:   return {1'b1, ALU_AND};
            F_OR:    return {1'b1, ALU_OR};
            F_XOR:   return {1'b1, ALU_XOR};
            F_NOR:   return {1'b1, ALU_NOR};
            F_SLT:   return {1'b1, ALU_SLT};
            F_SLTU:  return {1'b1, ALU_SLTU};
            F_SLL:   return {1'b1, ALU_SLL};
            F_SRL:   return {1'b1, ALU_SRL};
            F_SRA:   return {1'b1, ALU_SRA};
            default: return 5'b0;
        endcase
    endfunction

endpackage

// File: rtl/rcpu_regfile.sv
// rcpu_regfile: 32x32 register file, two operand read ports, one debug read port,
// one write port where a pipeline write beats a debug write to the same register.
module rcpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr_i,
    input  logic [4:0]  rb_addr_i,
    input  logic [4:0]  dbg_raddr_i,
    input  logic        pwe_i,
    input  logic [4:0]  pwaddr_i,
    input  logic [31:0] pwdata_i,
    input  logic        dwe_i,
    input  logic [4:0]  dwaddr_i,
    input  logic [31:0] dwdata_i,
    output logic [31:0] ra_data_o,
    output logic [31:0] rb_data_o,
    output logic [31:0] dbg_rdata_o
);

    logic [31:0] mem_q [32];

    // Index 0 is never written, so R0 stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (pwe_i && pwaddr_i == 5'(i)) mem_q[i] <= pwdata_i;
                else if (dwe_i && dwaddr_i == 5'(i)) mem_q[i] <= dwdata_i;
            end
        end
    end

    assign ra_data_o   = (ra_addr_i == 5'd0) ? 32'd0 : mem_q[ra_addr_i];
    assign rb_data_o   = (rb_addr_i == 5'd0) ? 32'd0 : mem_q[rb_addr_i];
    assign dbg_rdata_o = (dbg_raddr_i == 5'd0) ? 32'd0 : mem_q[dbg_raddr_i];

endmodule

// File: rtl/rtype_exec_stage.sv
// rtype_exec_stage: two-stage MIPS R-type pipeline (ID register read, EX/WB execute and
// write back) with result bypass from EX/WB into ID.
module rtype_exec_stage
    import rcpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_code,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_waddr,
    input  logic [31:0] dbg_wdata,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        zf,
    output logic        of,
    output logic        illegal,
    output logic        retire_v
);

    logic        id_v_q, legal_q;
    logic [3:0]  aluop_q;
    logic [4:0]  rd_q, shamt_q;
    logic [31:0] a_q, b_q;
    logic        wb_en_q, zf_q, of_q, illegal_q, retire_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;

    logic [4:0]  dec, rs, rt;
    logic [31:0] rf_a, rf_b, a_d, b_d, sum, diff, nb, res;
    logic        ovf, we;

    assign dec = decode(inst_code);
    assign rs  = f_rs(inst_code);
    assign rt  = f_rt(inst_code);

    rcpu_regfile u_rf (
        .clk        (clk),
        .rst        (rst),
        .ra_addr_i  (rs),
        .rb_addr_i  (rt),
        .dbg_raddr_i(dbg_raddr),
        .pwe_i      (we),
        .pwaddr_i   (rd_q),
        .pwdata_i   (res),
        .dwe_i      (dbg_we),
        .dwaddr_i   (dbg_waddr),
        .dwdata_i   (dbg_wdata),
        .ra_data_o  (rf_a),
        .rb_data_o  (rf_b),
        .dbg_rdata_o(dbg_rdata)
    );

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;
    assign nb   = ~b_q + 32'd1;

    always_comb begin
        res = '0;
        case (aluop_q)
            ALU_ADD, ALU_ADDU: res = sum;
            ALU_SUB, ALU_SUBU: res = diff;
            ALU_AND:  res = a_q & b_q;
            ALU_OR:   res = a_q | b_q;
            ALU_XOR:  res = a_q ^ b_q;
            ALU_NOR:  res = ~(a_q | b_q);
            ALU_SLT:  res = {31'd0, $signed(a_q) < $signed(b_q)};
            ALU_SLTU: res = {31'd0, a_q < b_q};
            ALU_SLL:  res = b_q << shamt_q;
            ALU_SRL:  res = b_q >> shamt_q;
            ALU_SRA:  res = $signed(b_q) >>> shamt_q;
            default:  res = '0;
        endcase
    end

    assign ovf = legal_q &&
                 ((aluop_q == ALU_ADD && a_q[31] == b_q[31] && sum[31] != a_q[31]) ||
                  (aluop_q == ALU_SUB && a_q[31] == nb[31] && diff[31] != a_q[31]));
    assign we  = id_v_q && legal_q && rd_q != 5'd0 && !ovf;

    // The register file only sees this write after the edge, so forward it now.
    assign a_d = (we && rd_q == rs) ? res : rf_a;
    assign b_d = (we && rd_q == rt) ? res : rf_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_v_q  <= 1'b0;
            legal_q <= 1'b0;
            aluop_q <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            id_v_q <= inst_valid;
            if (inst_valid) begin
                legal_q <= dec[4];
                aluop_q <= dec[3:0];
                rd_q    <= f_rd(inst_code);
                shamt_q <= f_shamt(inst_code);
                a_q     <= a_d;
                b_q     <= b_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            retire_q  <= id_v_q;
            wb_en_q   <= we;
            wb_addr_q <= id_v_q ? rd_q : 5'd0;
            wb_data_q <= (id_v_q && legal_q) ? res : 32'd0;
            zf_q      <= id_v_q && legal_q && res == 32'd0;
            of_q      <= id_v_q && ovf;
            illegal_q <= id_v_q && !legal_q;
        end
    end

    assign retire_v = retire_q;
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign zf       = zf_q;
    assign of       = of_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_rtype_exec_stage.sv
// tb_rtype_exec_stage: directed scenarios plus a randomized instruction stream checked
// against an instruction-level reference model of the register file.
module tb_rtype_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_code = '0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_waddr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;
    logic        wb_en, zf, of, illegal, retire_v;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic        rv;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        zf;
        logic        of;
        logic        ill;
    } exp_t;

    logic [31:0] mdl [32];

    rtype_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .inst_valid(inst_valid),
        .inst_code (inst_code),
        .dbg_we    (dbg_we),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .zf        (zf),
        .of        (of),
        .illegal   (illegal),
        .retire_v  (retire_v)
    );

    always #5 clk = ~clk;

    function automatic exp_t outs();
        return '{retire_v, wb_en, wb_addr, wb_data, zf, of, illegal};
    endfunction

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        dbg_we = 1'b1;
        dbg_waddr = a;
        dbg_wdata = d;
        @(posedge clk);
        #1 dbg_we = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        dbg_raddr = a;
        #1 d = dbg_rdata;
    endtask

    task automatic issue(input logic [31:0] w);
        inst_valid = 1'b1;
        inst_code = w;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        inst_code = '0;
        @(posedge clk);
        #1;
    endtask

    // Executes one instruction against the architectural model and returns its retire outputs.
    task automatic model_step(input logic [31:0] w, output exp_t e);
        logic [31:0] a, b, r, nb;
        logic        lg, o;
        longint      s;
        int          sh;
        a = mdl[w[25:21]];
        b = mdl[w[20:16]];
        sh = int'(w[10:6]);
        lg = 1'b1;
        o = 1'b0;
        r = '0;
        if (w[31:26] != 6'h00) lg = 1'b0;
        else begin
            case (w[5:0])
                6'h20: begin
                    r = a + b;
                    s = longint'($signed(a)) + longint'($signed(b));
                    o = s > 64'sd2147483647 || s < -64'sd2147483648;
                end
                6'h22: begin
                    r = a - b;
                    nb = -b;
                    s = longint'($signed(a)) + longint'($signed(nb));
                    o = s > 64'sd2147483647 || s < -64'sd2147483648;
                end
                6'h21: r = a + b;
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = $signed(b) >>> sh;
                default: lg = 1'b0;
            endcase
        end
        e.rv = 1'b1;
        e.addr = w[15:11];
        e.ill = !lg;
        e.of = lg && o;
        e.data = lg ? r : 32'd0;
        e.zf = lg && r == 32'd0;
        e.en = lg && !o && w[15:11] != 5'd0;
        if (e.en) mdl[w[15:11]] = r;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (outs() !== exp_t'(0)) $display("FAIL reset_held outputs=%h want 0", outs());
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (outs() !== exp_t'(0)) $display("FAIL reset_released outputs=%h want 0", outs());
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), d);
            n_total++;
            if (d !== 32'd0) $display("FAIL reset_reg R%0d=%h want 0", i, d);
            else n_pass++;
        end
    endtask

    task automatic test_add();
        logic [31:0] d;
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(32'h00221820);
        n_total++;
        if ({retire_v, wb_en, wb_addr, wb_data, of, zf, illegal} !== {1'b1, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 1'b0})
            $display("FAIL add_retire got v=%b en=%b addr=%0d data=%h of=%b zf=%b ill=%b want 1 1 3 0000000c 0 0 0",
                     retire_v, wb_en, wb_addr, wb_data, of, zf, illegal);
        else n_pass++;
        peek(5'd3, d);
        n_total++;
        if (d !== 32'd12) $display("FAIL add_r3 got %h want 0000000c", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        inst_valid = 1'b1;
        inst_code = 32'h00221820;
        @(posedge clk);
        #1 inst_code = 32'h00612022;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        inst_code = '0;
        n_total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'd12})
            $display("FAIL b2b_first got en=%b addr=%0d data=%h want 1 3 0000000c", wb_en, wb_addr, wb_data);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({retire_v, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd4, 32'd7})
            $display("FAIL b2b_bypass got v=%b en=%b addr=%0d data=%h want 1 1 4 00000007",
                     retire_v, wb_en, wb_addr, wb_data);
        else n_pass++;
        peek(5'd4, d);
        n_total++;
        if (d !== 32'd7) $display("FAIL b2b_r4 got %h want 00000007", d);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        dbg_write(5'd1, 32'h7FFFFFFF);
        dbg_write(5'd2, 32'd1);
        issue(32'h00221820);
        n_total++;
        if ({retire_v, of, wb_en, illegal} !== 4'b1100)
            $display("FAIL ovf_add got v=%b of=%b en=%b ill=%b want 1 1 0 0", retire_v, of, wb_en, illegal);
        else n_pass++;
        peek(5'd3, d);
        n_total++;
        if (d !== 32'd12) $display("FAIL ovf_r3_kept got %h want 0000000c", d);
        else n_pass++;
        issue(32'h00221821);
        n_total++;
        if ({of, wb_en, wb_data} !== {1'b0, 1'b1, 32'h80000000})
            $display("FAIL addu_wrap got of=%b en=%b data=%h want 0 1 80000000", of, wb_en, wb_data);
        else n_pass++;
        peek(5'd3, d);
        n_total++;
        if (d !== 32'h80000000) $display("FAIL addu_r3 got %h want 80000000", d);
        else n_pass++;
    endtask

    task automatic test_rd0_illegal_sra();
        logic [31:0] d;
        issue(32'h00220025);
        n_total++;
        if ({retire_v, wb_en, illegal} !== 3'b100)
            $display("FAIL rd0_or got v=%b en=%b ill=%b want 1 0 0", retire_v, wb_en, illegal);
        else n_pass++;
        peek(5'd0, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL rd0_r0 got %h want 0", d);
        else n_pass++;
        issue(32'h8C010000);
        n_total++;
        if ({retire_v, illegal, wb_en, of} !== 4'b1100)
            $display("FAIL illegal_lw got v=%b ill=%b en=%b of=%b want 1 1 0 0", retire_v, illegal, wb_en, of);
        else n_pass++;
        peek(5'd1, d);
        n_total++;
        if (d !== 32'h7FFFFFFF) $display("FAIL illegal_r1 got %h want 7fffffff", d);
        else n_pass++;
        dbg_write(5'd2, 32'h80000000);
        issue(32'h00021903);
        n_total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'hF8000000})
            $display("FAIL sra got en=%b addr=%0d data=%h want 1 3 f8000000", wb_en, wb_addr, wb_data);
        else n_pass++;
    endtask

    task automatic test_dbg_collision();
        logic [31:0] d;
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        inst_valid = 1'b1;
        inst_code = 32'h00221820;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        dbg_we = 1'b1;
        dbg_waddr = 5'd3;
        dbg_wdata = 32'h0000DEAD;
        @(posedge clk);
        #1 dbg_we = 1'b0;
        peek(5'd3, d);
        n_total++;
        if (d !== 32'd12) $display("FAIL collision_r3 got %h want 0000000c", d);
        else n_pass++;
        dbg_write(5'd0, 32'hFFFFFFFF);
        peek(5'd0, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL dbg_r0 got %h want 0", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        dbg_write(5'd5, 32'd100);
        dbg_write(5'd6, 32'd1);
        inst_valid = 1'b1;
        inst_code = 32'h00A63820;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        inst_code = '0;
        rst = 1'b1;
        #2;
        n_total++;
        if (outs() !== exp_t'(0)) $display("FAIL midrst_async outputs=%h want 0", outs());
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (outs() !== exp_t'(0)) $display("FAIL midrst_after outputs=%h want 0", outs());
        else n_pass++;
        peek(5'd7, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL midrst_r7 got %h want 0", d);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        logic [31:0] w, d;
        logic        v;
        exp_t        prev, cur;
        mdl[0] = '0;
        for (int i = 1; i < 32; i++) begin
            case ($urandom_range(0, 3))
                0: mdl[i] = 32'h7FFFFFFF - $urandom_range(0, 3);
                1: mdl[i] = 32'h80000000 + $urandom_range(0, 3);
                default: mdl[i] = $urandom;
            endcase
            dbg_write(5'(i), mdl[i]);
        end
        prev = '0;
        for (int k = 0; k < 300; k++) begin
            v = $urandom_range(0, 4) != 0;
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom;
                if (w[31:26] == 6'h00) w[31:26] = 6'h23;
            end else begin
                w = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom), fn[$urandom_range(0, 12)]};
            end
            inst_valid = v;
            inst_code = w;
            @(posedge clk);
            #1;
            n_total++;
            if (outs() !== prev) $display("FAIL rand_retire step=%0d got %h want %h", k, outs(), prev);
            else n_pass++;
            cur = '0;
            if (v) model_step(w, cur);
            prev = cur;
        end
        inst_valid = 1'b0;
        inst_code = '0;
        @(posedge clk);
        #1;
        n_total++;
        if (outs() !== prev) $display("FAIL rand_last got %h want %h", outs(), prev);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), d);
            n_total++;
            if (d !== mdl[i]) $display("FAIL rand_reg R%0d got %h want %h", i, d, mdl[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_overflow();
        test_rd0_illegal_sra();
        test_dbg_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
